// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester and memory-controller packet bus for mem_req_arbiter
//
// Signals (slave = the arbiter's view):
//   req_valid/req_write/req_addr/req_wdata  in   per-requester request (0 = icache, 1 = dcache)
//   req_ready                               out  one-hot grant, same cycle as the request
//   resp_valid/resp_write/resp_data         out  registered response routed to the ID's owner
//   mc_packet_type/mc_id/mc_addr/mc_data    out  registered one-cycle request packet to controller
//   mc_resp_type/mc_resp_id/mc_resp_data    in   controller response (101 write ack, 110 read data)
interface mem_req_arbiter_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 36
);
    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             req_ready;

    logic [1:0]             resp_valid;
    logic                   resp_write;
    logic [DATA_W-1:0]      resp_data;

    logic [2:0]             mc_packet_type;
    logic [3:0]             mc_id;
    logic [ADDR_W-1:0]      mc_addr;
    logic [DATA_W-1:0]      mc_data;

    logic [2:0]             mc_resp_type;
    logic [3:0]             mc_resp_id;
    logic [DATA_W-1:0]      mc_resp_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_write, resp_data,
        output mc_packet_type, mc_id, mc_addr, mc_data,
        input  mc_resp_type, mc_resp_id, mc_resp_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_write, resp_data,
        input  mc_packet_type, mc_id, mc_addr, mc_data,
        output mc_resp_type, mc_resp_id, mc_resp_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin icache/dcache arbiter with 16-entry transaction ID pool
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            mem_req_arbiter_if.slave (requests, responses, controller packets)
//   drain_req      stop granting and wait for every ID to come back
//   drain_done     high while drained
//   id_err         sticky, response seen for an ID that is not busy
// Optional (MEM_REQ_ARB_STATS_EN defined):
//   stat_clr       synchronous clear of the counters
//   stat_grants0/1 saturating grant counts per requester
//   stat_stall_cycles saturating count of cycles with a request pending but no grant
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int DATA_W          = 512,
    parameter int ADDR_W          = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_req_arbiter_if.slave     bus,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 id_err
`ifdef MEM_REQ_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_grants0,
    output logic [31:0]          stat_grants1,
    output logic [31:0]          stat_stall_cycles
`endif
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      busy, busy_nxt;
    logic [15:0]      owner;
    logic             rr;
    logic [1:0][4:0]  out_cnt;

    logic [1:0]       elig;
    logic             grant;
    logic             winner;
    logic [1:0]       ready;
    logic [3:0]       alloc_id;

    logic             resp_known;
    logic             resp_hit;
    logic             resp_owner;

    logic [2:0]        mc_type_q;
    logic [3:0]        mc_id_q;
    logic [ADDR_W-1:0] mc_addr_q;
    logic [DATA_W-1:0] mc_data_q;
    logic [1:0]        resp_valid_q;
    logic              resp_write_q;
    logic [DATA_W-1:0] resp_data_q;

    // Eligibility uses only registered state, so an ID freed this cycle
    // cannot be handed out until the next one. rst_n gating keeps the
    // combinational grant low while reset is held.
    always_comb begin
        elig = 2'b00;
        for (int r = 0; r < 2; r++) begin
            elig[r] = rst_n && bus.req_valid[r] && (state == ST_RUN) &&
                      (out_cnt[r] < MAX_CNT) && !(&busy);
        end
        grant  = |elig;
        winner = (elig[0] && elig[1]) ? rr : elig[1];
        ready  = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    end

    // Lowest-index free ID: scan downward so the last hit wins.
    always_comb begin
        alloc_id = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_id = 4'(i);
            end
        end
    end

    always_comb begin
        resp_known = (bus.mc_resp_type == 3'b101) || (bus.mc_resp_type == 3'b110);
        resp_hit   = resp_known && busy[bus.mc_resp_id];
        resp_owner = owner[bus.mc_resp_id];
        busy_nxt   = busy;
        if (resp_hit) begin
            busy_nxt[bus.mc_resp_id] = 1'b0;
        end
        if (grant) begin
            busy_nxt[alloc_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            owner        <= '0;
            rr           <= 1'b0;
            out_cnt      <= '0;
            mc_type_q    <= 3'b000;
            mc_id_q      <= '0;
            mc_addr_q    <= '0;
            mc_data_q    <= '0;
            resp_valid_q <= 2'b00;
            resp_write_q <= 1'b0;
            resp_data_q  <= '0;
            id_err       <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (grant) begin
                owner[alloc_id] <= winner;
                rr              <= ~winner;
            end

            // Grant and response to the same owner cancel out.
            for (int r = 0; r < 2; r++) begin
                out_cnt[r] <= out_cnt[r]
                            + {4'b0, (grant && (winner == 1'(r)))}
                            - {4'b0, (resp_hit && (resp_owner == 1'(r)))};
            end

            if (grant) begin
                mc_type_q <= bus.req_write[winner] ? 3'b001 : 3'b011;
                mc_id_q   <= alloc_id;
                mc_addr_q <= bus.req_addr[winner];
                mc_data_q <= bus.req_write[winner] ? bus.req_wdata[winner] : '0;
            end else begin
                mc_type_q <= 3'b000;
                mc_id_q   <= '0;
                mc_addr_q <= '0;
                mc_data_q <= '0;
            end

            if (resp_hit) begin
                resp_valid_q <= resp_owner ? 2'b10 : 2'b01;
                resp_write_q <= (bus.mc_resp_type == 3'b101);
                resp_data_q  <= bus.mc_resp_data;
            end else begin
                resp_valid_q <= 2'b00;
                resp_write_q <= 1'b0;
                resp_data_q  <= '0;
            end

            if (resp_known && !busy[bus.mc_resp_id]) begin
                id_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN also waits for the last packet to leave the mc_* register.
    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            ST_RUN: begin
                if (drain_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((busy == 16'h0000) && (mc_type_q == 3'b000)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                drain_done = 1'b1;
                if (!drain_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.req_ready      = ready;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_write     = resp_write_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.mc_packet_type = mc_type_q;
    assign bus.mc_id          = mc_id_q;
    assign bus.mc_addr        = mc_addr_q;
    assign bus.mc_data        = mc_data_q;

`ifdef MEM_REQ_ARB_STATS_EN
    logic stall;
    assign stall = (|bus.req_valid) && !grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants0      <= '0;
            stat_grants1      <= '0;
            stat_stall_cycles <= '0;
        end else if (stat_clr) begin
            stat_grants0      <= '0;
            stat_grants1      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (grant && !winner && (stat_grants0 != 32'hFFFF_FFFF)) begin
                stat_grants0 <= stat_grants0 + 32'd1;
            end
            if (grant && winner && (stat_grants1 != 32'hFFFF_FFFF)) begin
                stat_grants1 <= stat_grants1 + 32'd1;
            end
            if (stall && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drain_req = 1'b0;
    logic drain_done;
    logic id_err;

    int total = 0;
    int bad   = 0;

    mem_req_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_req_arbiter #(
        .MAX_OUTSTANDING(8),
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .drain_req(drain_req),
        .drain_done(drain_done),
        .id_err(id_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] w);
        bus.req_valid = v;
        bus.req_write = w;
    endtask

    task automatic set_resp(input logic [2:0] t, input logic [3:0] id, input logic [DW-1:0] d);
        bus.mc_resp_type = t;
        bus.mc_resp_id   = id;
        bus.mc_resp_data = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'h0);
        chk({tag, "_rvalid"}, 64'(bus.resp_valid), 64'h0);
        chk({tag, "_mctype"}, 64'(bus.mc_packet_type), 64'h0);
        chk({tag, "_mcid"}, 64'(bus.mc_id), 64'h0);
        chk({tag, "_mcaddr"}, 64'(bus.mc_addr), 64'h0);
        chk({tag, "_done"}, 64'(drain_done), 64'h0);
        chk({tag, "_iderr"}, 64'(id_err), 64'h0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        set_req(2'b00, 2'b00);
        set_resp(3'b000, 4'd0, '0);
        drain_req = 1'b0;
        settle();
        chk_all_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_addr[0]  = 16'h1000;
        bus.req_addr[1]  = 16'h2000;
        bus.req_wdata[0] = 32'hAAAA_0000;
        bus.req_wdata[1] = 32'hBBBB_1111;
        set_req(2'b00, 2'b00);
        set_resp(3'b000, 4'd0, '0);

        // Alternation, pointer hold across an idle cycle, read/write packets
        do_reset();
        tick(); set_req(2'b11, 2'b10); settle();
        chk("alt_g0", 64'(bus.req_ready), 64'h1);
        tick(); settle();
        chk("alt_g1", 64'(bus.req_ready), 64'h2);
        chk("alt_p0_type", 64'(bus.mc_packet_type), 64'h3);
        chk("alt_p0_id", 64'(bus.mc_id), 64'h0);
        chk("alt_p0_addr", 64'(bus.mc_addr), 64'h1000);
        chk("alt_p0_data", 64'(bus.mc_data), 64'h0);
        tick(); settle();
        chk("alt_g2", 64'(bus.req_ready), 64'h1);
        chk("alt_p1_type", 64'(bus.mc_packet_type), 64'h1);
        chk("alt_p1_id", 64'(bus.mc_id), 64'h1);
        chk("alt_p1_addr", 64'(bus.mc_addr), 64'h2000);
        chk("alt_p1_data", 64'(bus.mc_data), 64'hBBBB1111);
        tick(); set_req(2'b00, 2'b10); settle();
        chk("alt_idle_ready", 64'(bus.req_ready), 64'h0);
        chk("alt_p2_id", 64'(bus.mc_id), 64'h2);
        tick(); set_req(2'b11, 2'b10); settle();
        chk("alt_hold_g", 64'(bus.req_ready), 64'h2);
        chk("alt_idle_type", 64'(bus.mc_packet_type), 64'h0);
        tick(); settle();
        chk("alt_g4", 64'(bus.req_ready), 64'h1);
        chk("alt_p3_id", 64'(bus.mc_id), 64'h3);
        chk("alt_p3_type", 64'(bus.mc_packet_type), 64'h1);
        tick(); set_req(2'b00, 2'b00); settle();
        chk("alt_p4_id", 64'(bus.mc_id), 64'h4);
        tick(); set_resp(3'b110, 4'd2, 32'h1234_5678); settle();
        tick(); set_resp(3'b101, 4'd3, 32'h0); settle();
        chk("rsp_rd_valid", 64'(bus.resp_valid), 64'h1);
        chk("rsp_rd_write", 64'(bus.resp_write), 64'h0);
        chk("rsp_rd_data", 64'(bus.resp_data), 64'h12345678);
        tick(); set_resp(3'b000, 4'd0, '0); settle();
        chk("rsp_wr_valid", 64'(bus.resp_valid), 64'h2);
        chk("rsp_wr_write", 64'(bus.resp_write), 64'h1);
        tick(); settle();
        chk("rsp_none", 64'(bus.resp_valid), 64'h0);
        chk("rsp_iderr", 64'(id_err), 64'h0);

        // Outstanding limit on requester 1
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(); set_req(2'b10, 2'b00); settle();
            chk($sformatf("max_g%0d", k), 64'(bus.req_ready), 64'h2);
        end
        tick(); set_req(2'b11, 2'b00); settle();
        chk("max_r0_a", 64'(bus.req_ready), 64'h1);
        tick(); settle();
        chk("max_r0_b", 64'(bus.req_ready), 64'h1);
        tick(); set_req(2'b10, 2'b00); set_resp(3'b110, 4'd4, 32'hD00D_0004); settle();
        chk("max_stall", 64'(bus.req_ready), 64'h0);
        tick(); set_resp(3'b000, 4'd0, '0); settle();
        chk("max_release", 64'(bus.req_ready), 64'h2);
        chk("max_rvalid", 64'(bus.resp_valid), 64'h2);
        chk("max_rdata", 64'(bus.resp_data), 64'hD00D0004);
        tick(); set_req(2'b00, 2'b00); settle();
        chk("max_reuse_id", 64'(bus.mc_id), 64'h4);
        chk("max_reuse_type", 64'(bus.mc_packet_type), 64'h3);

        // Full pool
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick(); set_req(2'b11, 2'b00); settle();
            chk($sformatf("full_g%0d", k), 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
        end
        tick(); settle();
        chk("full_stall", 64'(bus.req_ready), 64'h0);
        chk("full_last_id", 64'(bus.mc_id), 64'hF);
        tick(); set_resp(3'b110, 4'd5, 32'hCAFE_0005); settle();
        chk("full_stall2", 64'(bus.req_ready), 64'h0);
        tick(); set_resp(3'b000, 4'd0, '0); settle();
        chk("full_rvalid", 64'(bus.resp_valid), 64'h2);
        chk("full_rdata", 64'(bus.resp_data), 64'hCAFE0005);
        chk("full_regrant", 64'(bus.req_ready), 64'h2);
        tick(); settle();
        chk("full_id5", 64'(bus.mc_id), 64'h5);
        chk("full_stall3", 64'(bus.req_ready), 64'h0);

        // Response for a free ID
        do_reset();
        tick(); set_resp(3'b010, 4'd9, 32'h0); settle();
        tick(); set_resp(3'b101, 4'd9, 32'h0); settle();
        chk("err_other_type", 64'(id_err), 64'h0);
        tick(); set_resp(3'b000, 4'd0, '0); settle();
        chk("err_set", 64'(id_err), 64'h1);
        chk("err_no_rvalid", 64'(bus.resp_valid), 64'h0);
        tick(); tick(); tick(); settle();
        chk("err_sticky", 64'(id_err), 64'h1);

        // Drain with three outstanding
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(); set_req(2'b01, 2'b00); settle();
            chk($sformatf("drn_g%0d", k), 64'(bus.req_ready), 64'h1);
        end
        tick(); set_req(2'b00, 2'b00); drain_req = 1'b1; settle();
        tick(); set_req(2'b01, 2'b00); set_resp(3'b110, 4'd0, 32'h0); settle();
        chk("drn_nogrant", 64'(bus.req_ready), 64'h0);
        chk("drn_busy_done", 64'(drain_done), 64'h0);
        tick(); set_resp(3'b110, 4'd1, 32'h0); settle();
        tick(); set_resp(3'b101, 4'd2, 32'h0); settle();
        chk("drn_nogrant2", 64'(bus.req_ready), 64'h0);
        tick(); set_resp(3'b000, 4'd0, '0); settle();
        chk("drn_last_rvalid", 64'(bus.resp_valid), 64'h1);
        chk("drn_not_yet", 64'(drain_done), 64'h0);
        tick(); settle();
        chk("drn_done", 64'(drain_done), 64'h1);
        chk("drn_done_nogrant", 64'(bus.req_ready), 64'h0);
        tick(); drain_req = 1'b0; settle();
        chk("drn_done_hold", 64'(drain_done), 64'h1);
        tick(); settle();
        chk("drn_resume", 64'(bus.req_ready), 64'h1);
        chk("drn_resume_done", 64'(drain_done), 64'h0);
        tick(); set_req(2'b00, 2'b00); settle();
        chk("drn_resume_id", 64'(bus.mc_id), 64'h0);
        chk("drn_iderr", 64'(id_err), 64'h0);

        // Drain from idle
        do_reset();
        tick(); drain_req = 1'b1; settle();
        chk("drn0_e0", 64'(drain_done), 64'h0);
        tick(); settle();
        chk("drn0_e1", 64'(drain_done), 64'h0);
        tick(); settle();
        chk("drn0_e2", 64'(drain_done), 64'h1);
        tick(); drain_req = 1'b0;

        // Reset in the middle of a burst
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(); set_req(2'b11, 2'b00); settle();
        end
        tick(); #2;
        chk("mid_pre_id", 64'(bus.mc_id), 64'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 64'(bus.req_ready), 64'h0);
        chk("mid_type", 64'(bus.mc_packet_type), 64'h0);
        chk("mid_id", 64'(bus.mc_id), 64'h0);
        chk("mid_addr", 64'(bus.mc_addr), 64'h0);
        tick(); rst_n = 1'b1; settle();
        chk("mid_rr", 64'(bus.req_ready), 64'h1);
        tick(); set_req(2'b00, 2'b00); settle();
        chk("mid_id_reuse", 64'(bus.mc_id), 64'h0);
        tick(); set_resp(3'b110, 4'd2, 32'h0); settle();
        tick(); set_resp(3'b000, 4'd0, '0); settle();
        chk("mid_lost_iderr", 64'(id_err), 64'h1);
        chk("mid_lost_rvalid", 64'(bus.resp_valid), 64'h0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
